// File: rtl/alu_uart_interface.sv
// Frame sequencer between the UART and the ALU: collects A, B, opcode, latches the
// ALU result one cycle later and hands it to the transmitter with a start/done handshake.
//
// state     | meaning
// WAIT_A    | idle, next byte is operand A
// WAIT_B    | A held, waiting for operand B (inter-byte timer running)
// WAIT_OP   | B held, waiting for opcode (inter-byte timer running)
// COMPUTE   | ALU sees new opcode, result latched into tx_data
// SEND      | tx_start pulse
// WAIT_TX   | holding tx_data until the transmitter reports done
module alu_uart_interface #(
    parameter int NB_DATA = 8,
    parameter int TIMEOUT = 1000000
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_alu_res,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_dato_a,
    output logic [NB_DATA-1:0] o_dato_b,
    output logic [NB_DATA-1:0] o_op,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_overrun
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TC_INT = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] TC = CNT_W'(TC_INT);

    typedef enum logic [2:0] {
        S_WAIT_A,
        S_WAIT_B,
        S_WAIT_OP,
        S_COMPUTE,
        S_SEND,
        S_WAIT_TX
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [NB_DATA-1:0] r_dato_a;
    logic [NB_DATA-1:0] r_dato_b;
    logic [NB_DATA-1:0] r_op;
    logic [NB_DATA-1:0] r_tx_data;
    logic               r_tx_start;
    logic               r_busy;
    logic               r_overrun;
    logic               w_expired;

    // A byte landing on the expiry cycle wins over the timeout.
    assign w_expired = (TIMEOUT > 0) && (r_cnt == TC) && !i_rx_done;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_WAIT_A;
            r_cnt      <= '0;
            r_dato_a   <= '0;
            r_dato_b   <= '0;
            r_op       <= '0;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
            r_busy     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;
            // r_busy mirrors COMPUTE/SEND/WAIT_TX, exactly where bytes are dropped.
            if (i_rx_done && r_busy) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                S_WAIT_A: begin
                    r_cnt <= '0;
                    if (i_rx_done) begin
                        r_dato_a <= i_rx_data;
                        r_state  <= S_WAIT_B;
                    end
                end
                S_WAIT_B: begin
                    if (i_rx_done) begin
                        r_dato_b <= i_rx_data;
                        r_cnt    <= '0;
                        r_state  <= S_WAIT_OP;
                    end else if (w_expired) begin
                        r_cnt   <= '0;
                        r_state <= S_WAIT_A;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT_OP: begin
                    if (i_rx_done) begin
                        r_op    <= i_rx_data;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_COMPUTE;
                    end else if (w_expired) begin
                        r_cnt   <= '0;
                        r_state <= S_WAIT_A;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_COMPUTE: begin
                    r_tx_data  <= i_alu_res;
                    r_tx_start <= 1'b1;
                    r_state    <= S_SEND;
                end
                S_SEND: begin
                    r_state <= S_WAIT_TX;
                end
                S_WAIT_TX: begin
                    if (i_tx_done) begin
                        r_busy  <= 1'b0;
                        r_state <= S_WAIT_A;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_WAIT_A;
                end
            endcase
        end
    end

    assign o_dato_a   = r_dato_a;
    assign o_dato_b   = r_dato_b;
    assign o_op       = r_op;
    assign o_tx_data  = r_tx_data;
    assign o_tx_start = r_tx_start;
    assign o_busy     = r_busy;
    assign o_overrun  = r_overrun;

endmodule

// File: doc/alu_uart_interface.md
# alu_uart_interface

- Sequencing stage directly upstream of the ALU.
- Collects three bytes from the UART receiver in order: operand A, operand B, opcode.
- Drives them as registered inputs to the combinational ALU, captures the ALU result one cycle later and hands it to the UART transmitter with a start/done handshake.
- Discards incomplete frames after an inter-byte timeout.
- Flags bytes that arrive while a result is still in flight.

## Interface

- `nb_data`, 8: width of operands, opcode, result and UART bytes.
- `timeout`, 1000000: clock cycles allowed between bytes of one frame; 0 disables the timeout.
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `rx_data` in nb_data: received byte, valid when `rx_done` is high.
- `rx_done` in 1: one-cycle pulse from the UART receiver.
- `alu_res` in nb_data: combinational result from the ALU.
- `tx_done` in 1: one-cycle pulse from the UART transmitter when the byte is fully sent.
- `dato_a` out nb_data: registered operand A to the ALU (signed interpretation downstream).
- `dato_b` out nb_data: registered operand B to the ALU.
- `op` out nb_data: registered opcode to the ALU.
- `tx_data` out nb_data: byte to transmit, stable from `tx_start` until `tx_done`.
- `tx_start` out 1: one-cycle pulse requesting transmission.
- `busy` out 1: high in COMPUTE, SEND and WAIT_TX.
- `overrun` out 1: sticky; set when a byte is dropped.

## Operation

**States.** WAIT_A, WAIT_B, WAIT_OP, COMPUTE, SEND, WAIT_TX. Reset state is WAIT_A.

**Reset values.**
- `dato_a`, `dato_b`, `op`, `tx_data` = 0.
- `tx_start`, `busy`, `overrun` = 0.
- Timeout counter = 0.

**Frame collection.**
- WAIT_A, on `rx_done`: load `dato_a` from `rx_data`, go to WAIT_B.
- WAIT_B, on `rx_done`: load `dato_b`, go to WAIT_OP.
- WAIT_OP, on `rx_done`: load `op`, go to COMPUTE.

**Result handling.**
- COMPUTE: the ALU sees the new `op`. Latch `alu_res` into `tx_data`, go to SEND. No decoding of `op` here; unknown opcodes pass through and the ALU's default result is transmitted.
- SEND: `tx_start` = 1 for exactly this cycle, go to WAIT_TX.
- WAIT_TX: hold all outputs. On `tx_done`, go to WAIT_A.
- `dato_a`, `dato_b` and `op` keep their last values between frames; the ALU output stays valid for external display.

**Timeout** (only when `timeout` > 0).
- The counter clears on every accepted byte and increments each cycle in WAIT_B and WAIT_OP.
- On the cycle it equals `timeout`-1 with no `rx_done`, go to WAIT_A.
- Operand registers are not cleared on timeout.
- If `rx_done` arrives on the expiry cycle, the byte is accepted and the timeout does not fire.

**Dropped bytes.** `rx_done` in COMPUTE, SEND or WAIT_TX drops the byte and sets `overrun`. `overrun` clears only on `reset`.

**Other boundary rules.**
- `tx_done` outside WAIT_TX is ignored.
- `rx_done` and `tx_done` in the same WAIT_TX cycle: `tx_done` is honoured, go to WAIT_A, the byte is dropped and `overrun` is set.
- `reset` asserted in any state, including mid-frame or during WAIT_TX: all registers go to their reset values on the next edge, and any partially collected frame is lost.

## Timing

- Opcode `rx_done` at cycle n:
  - `op` updated at n+1 (state COMPUTE).
  - `tx_data` valid at n+2.
  - `tx_start` high during n+2 only.
  - `busy` high from n+1 until the cycle after `tx_done`.
- Operand byte at cycle n: register updated at n+1.
- A byte is accepted on every cycle `rx_done` is high in a WAIT_A/B/OP state; back-to-back pulses are legal.
- Minimum frame-to-frame turnaround: the next A byte is accepted on the cycle after `tx_done`.

## Test plan

- Bytes 0x05, 0x03, 0x20 (ADD), with the ALU model attached, produce:
  - `dato_a`=0x05, `dato_b`=0x03, `op`=0x20;
  - `tx_data`=0x08 and one `tx_start` pulse exactly 2 cycles after the third `rx_done`;
  - after `tx_done`, state returns to WAIT_A and `busy`=0.
- Bytes 0x03, 0x05, 0x22 (SUB) give `tx_data`=0xFE. Then 0xF0, 0x02, 0x03 (SRA) gives 0xFC, and 0xFF, 0x00, 0x55 (undefined opcode) gives 0xAA.
- Timeout set to 16:
  - 0x11 then silence for 16 cycles returns to WAIT_A.
  - Next bytes 0x22, 0x33, 0x24 produce `dato_a`=0x22 and `tx_data`=0x22.
  - A byte arriving on the expiry cycle is accepted as B.
- `rx_done` with 0x77 during WAIT_TX: byte dropped, `overrun`=1, `dato_a` unchanged.
  - Repeat with `rx_done` coincident with `tx_done`: `overrun`=1 and state goes to WAIT_A.
- `reset` pulsed after two bytes, and again during WAIT_TX: every output returns to 0, and a following full frame completes normally.
